// File: rtl/rr_mux_pkg.sv
// ---------------------------------------------------------------------------
// rr_mux_pkg
// Shared types and helpers for the round-robin mux arbiter.
//   state_t  : arbiter FSM states (IDLE, GRANT)
//   NUM_REQ  : number of requesters sharing the mux
//   onehot() : 2-bit index -> 4-bit one-hot grant vector
//   pick()   : round-robin search, first set request bit starting at ptr
// ---------------------------------------------------------------------------
package rr_mux_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // Scans from the farthest candidate back to ptr so the last hit kept is
    // the nearest one in round-robin order (ptr, ptr+1, ... mod 4).
    function automatic logic [1:0] pick(input logic [1:0]         ptr,
                                        input logic [NUM_REQ-1:0] req);
        logic [1:0] idx;
        logic [1:0] res;
        res = ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                res = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux4.sv
// ---------------------------------------------------------------------------
// mux4
// Purely combinational 4:1 multiplexer, WIDTH bits per input.
//   data_in : packed inputs, input i at data_in[i*WIDTH +: WIDTH]
//   sel     : input index
//   y       : selected input
// ---------------------------------------------------------------------------
module mux4 #(
    parameter int WIDTH = 2
) (
    input  logic [4*WIDTH-1:0] data_in,
    input  logic [1:0]         sel,
    output logic [WIDTH-1:0]   y
);

    always_comb begin
        y = '0;
        case (sel)
            2'd0:    y = data_in[0*WIDTH +: WIDTH];
            2'd1:    y = data_in[1*WIDTH +: WIDTH];
            2'd2:    y = data_in[2*WIDTH +: WIDTH];
            default: y = data_in[3*WIDTH +: WIDTH];
        endcase
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter
// Round-robin arbiter sharing one 4:1 WIDTH-bit mux output between four
// requesters. Each grant lasts at most HOLD cycles; a requester that drops
// its request releases the output on the next edge.
//   CLOCK_50 : clock, rising edge
//   reset    : asynchronous, active-high
//   req      : request vector, bit i = requester i
//   data_in  : packed requester data, requester i at data_in[i*WIDTH +: WIDTH]
//   gnt      : registered one-hot grant (zero when idle)
//   sel      : registered index of granted requester (holds last value idle)
//   valid    : high while a grant is active
//   m        : data of requester sel while valid, else 0 (combinational)
// ---------------------------------------------------------------------------
module rr_mux_arbiter
    import rr_mux_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int HOLD  = 4
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   data_in,
    output logic [3:0]           gnt,
    output logic [1:0]           sel,
    output logic                 valid,
    output logic [WIDTH-1:0]     m
);

    localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

    state_t     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic       valid_q, valid_d;
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic [3:0] masked_req;
    logic [WIDTH-1:0] mux_y;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            sel_q      <= '0;
            valid_q    <= 1'b0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            valid_q    <= valid_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        valid_d    = valid_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        // The requester whose grant is ending may not win the same edge.
        masked_req = req & ~onehot(sel_q);

        case (state_q)
            IDLE: begin
                if (req != 4'b0000) begin
                    sel_d      = pick(rr_ptr_q, req);
                    gnt_d      = onehot(sel_d);
                    valid_d    = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = GRANT;
                end else begin
                    gnt_d   = '0;
                    valid_d = 1'b0;
                end
            end

            GRANT: begin
                if (!req[sel_q] || (hold_cnt_q == HOLD_LAST)) begin
                    rr_ptr_d   = sel_q + 2'd1;
                    hold_cnt_d = '0;
                    if (masked_req != 4'b0000) begin
                        // Hand over directly, no idle bubble.
                        sel_d = pick(sel_q + 2'd1, masked_req);
                        gnt_d = onehot(sel_d);
                    end else begin
                        gnt_d   = '0;
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    mux4 #(.WIDTH(WIDTH)) u_mux4 (
        .data_in (data_in),
        .sel     (sel_q),
        .y       (mux_y)
    );

    assign gnt   = gnt_q;
    assign sel   = sel_q;
    assign valid = valid_q;
    assign m     = valid_q ? mux_y : '0;

endmodule
